// File: rtl/accum_invariant_monitor.sv
// Shadow checker for the selector-gated accumulator (x += y, y += 1 while y < LIMIT).
// Optional hold-timeout detector enabled by defining MON_STALL_TIMEOUT_EN.
module accum_invariant_monitor #(
  parameter int unsigned W         = 15,
  parameter int unsigned LIMIT     = 200,
  parameter int unsigned X_INIT    = 1,
  parameter int unsigned STALL_MAX = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic [1:0]   state,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [W-1:0] step_count,
  output logic [W-1:0] shadow_x,
  output logic [W-1:0] shadow_y,
  output logic         stall
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0]   CODE_NONE  = 2'd0;
  localparam logic [1:0]   CODE_INIT  = 2'd1;
  localparam logic [1:0]   CODE_TRANS = 2'd2;
  localparam logic [1:0]   CODE_INV   = 2'd3;
  localparam logic [W-1:0] LIMIT_W    = W'(LIMIT);
  localparam logic [W-1:0] X_INIT_W   = W'(X_INIT);
  localparam logic [W-1:0] CNT_MAX    = '1;

  state_t       state_q, state_d;
  logic         done_d, err_d;
  logic [1:0]   code_d;
  logic [W-1:0] cnt_d, sx_d, sy_d;

  // Sample classification against the shadow registers
  logic [W-1:0] x_next;
  logic [W:0]   y_next;
  logic         is_hold, is_step, inv_bad;

  assign x_next  = W'({1'b0, shadow_x} + {1'b0, shadow_y});
  assign y_next  = {1'b0, shadow_y} + (W+1)'(1);
  assign is_hold = (in_x == shadow_x) && (in_y == shadow_y);
  assign is_step = (shadow_y < LIMIT_W) && ({1'b0, in_y} == y_next) && (in_x == x_next);
  assign inv_bad = (in_y >= LIMIT_W) && (in_x < in_y);

  always_comb begin
    state_d = state_q;
    code_d  = err_code;
    cnt_d   = step_count;
    sx_d    = shadow_x;
    sy_d    = shadow_y;
    if (in_valid) begin
      unique case (state_q)
        ST_INIT: begin
          if (in_x == X_INIT_W && in_y == '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FAIL;
            code_d  = CODE_INIT;
          end
        end
        ST_RUN, ST_DONE: begin
          if (inv_bad) begin
            state_d = ST_FAIL;
            code_d  = CODE_INV;
          end else if (is_hold) begin
            state_d = state_q;
          end else if (is_step && state_q == ST_RUN) begin
            sx_d = in_x;
            sy_d = in_y;
            if (step_count != CNT_MAX) cnt_d = step_count + W'(1);
            if (in_y == LIMIT_W) state_d = ST_DONE;
          end else begin
            state_d = ST_FAIL;
            code_d  = CODE_TRANS;
          end
        end
        default: state_d = ST_FAIL;
      endcase
    end
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= CODE_NONE;
      step_count <= '0;
      shadow_x   <= X_INIT_W;
      shadow_y   <= '0;
    end else begin
      state_q    <= state_d;
      done       <= done_d;
      err        <= err_d;
      err_code   <= code_d;
      step_count <= cnt_d;
      shadow_x   <= sx_d;
      shadow_y   <= sy_d;
    end
  end

  assign state = state_q;

`ifdef MON_STALL_TIMEOUT_EN
  localparam int unsigned HOLD_W    = $clog2(STALL_MAX) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STALL_MAX);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              stall_d;
  logic              run_hold, run_step;

  assign run_hold = in_valid && (state_q == ST_RUN) && !inv_bad && is_hold;
  assign run_step = in_valid && (state_q == ST_RUN) && !inv_bad && !is_hold && is_step;

  // Consecutive-hold counter; stall stays latched until a step or reset
  always_comb begin
    hold_d  = hold_q;
    stall_d = stall;
    if (run_step) begin
      hold_d  = '0;
      stall_d = 1'b0;
    end else if (run_hold && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end
    if (hold_d == HOLD_MAX) stall_d = 1'b1;
    if (state_d != ST_RUN) hold_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      stall  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      stall  <= stall_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: doc/accum_invariant_monitor.md
Name: accum_invariant_monitor

Overview:
- Downstream consumer of the selector-gated accumulator stage (x += y, y += 1 while y < LIMIT).
- Samples the producer's x/y registers every valid cycle and advances its own shadow model.
- Classifies each sample as HOLD, STEP or illegal, and raises a sticky error with a code.
- Reports completion when y reaches LIMIT; used as an in-design checker and as a property-mining observation point.

Parameters:
W, 15, width of x/y datapath and step counter
LIMIT, 200, y value at which the producer stops stepping
X_INIT, 1, producer's x reset value (y reset value is 0)
STALL_MAX, 1024, consecutive-hold threshold (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_x/in_y hold a valid producer sample this cycle
in_x  input  W  producer x register
in_y  input  W  producer y register
state  output  2  0=INIT 1=RUN 2=DONE 3=FAIL
done  output  1  high while state==DONE
err  output  1  sticky error flag
err_code  output  2  0 none, 1 bad init, 2 illegal transition, 3 invariant violation
step_count  output  W  number of accepted STEP samples, saturating at all-ones
shadow_x  output  W  last accepted x
shadow_y  output  W  last accepted y
stall  output  1  hold-timeout flag (optional feature; 0 when compiled out)

Behaviour:
- Reset is on clk, synchronous, active-high: rst synchronous, active-high; clock clk. Reset has priority over everything, including mid-run or in FAIL.
- Reset values:
  - state=INIT, err=0, err_code=0, step_count=0
  - shadow_x=X_INIT, shadow_y=0, done=0, stall=0
- All outputs are registered. A sample in cycle N is reflected in the outputs at cycle N+1.
- in_valid=0: no state, counter or shadow change.
- INIT, valid sample:
  - (in_x,in_y)==(X_INIT,0) -> RUN.
  - Otherwise -> FAIL with code 1.
- RUN/DONE classification of a valid sample against (sx,sy)=(shadow_x,shadow_y):
  - HOLD: in_x==sx and in_y==sy. Accepted, no counter change.
  - STEP: sy<LIMIT and in_y==sy+1 and in_x==(sx+sy) mod 2^W. Accepted.
    - sx+sy is computed W+1 wide and truncated, mirroring producer wrap.
    - Shadows update; step_count increments unless saturated.
  - Anything else -> FAIL with code 2. This includes any STEP attempted while in DONE.
- Invariant check, every valid sample in RUN/DONE: in_y>=LIMIT and in_x<in_y -> FAIL with code 3.
  - Code 3 has priority over code 2 when both hold.
- RUN -> DONE when an accepted STEP makes the new shadow_y equal LIMIT.
- DONE accepts HOLD samples only.
- FAIL is absorbing until rst:
  - err=1; err_code holds the first error's code.
  - Shadows and step_count freeze at their last accepted values.
- done=1 only in DONE. err=1 only in FAIL.

Optional Feature:
- Macro: MON_STALL_TIMEOUT_EN.
- Defined:
  - A hold counter (width = clog2(STALL_MAX)+1) counts consecutive valid HOLD samples in RUN only.
  - It clears on STEP, on leaving RUN, and on rst.
  - When the count reaches STALL_MAX, stall is set and stays set until the next STEP or rst.
  - stall is non-fatal: it does not affect state or err.
- Undefined: no counter is built, and the stall port is driven constant 0.

Test Plan:
- Nominal run:
  - Stimulus: rst, then valid (1,0), then 200 steps (x+=y, y+=1).
  - Response: state=DONE, done=1, shadow_x=19901, shadow_y=200, step_count=200, err=0.
- Holds interleaved:
  - Stimulus: nominal run with random holds and in_valid=0 gaps.
  - Response: identical final values to the nominal run; err=0 throughout.
- Bad init:
  - Stimulus: first valid sample (2,0).
  - Response: next cycle state=FAIL, err=1, err_code=1, shadow_x=1.
- Illegal skip:
  - Stimulus: after (1,0), present (1,2).
  - Response: err_code=2, shadow_y stays 0.
  - Stimulus: from DONE, present (19901,201).
  - Response: err_code=2.
- Invariant priority:
  - Stimulus: in RUN at (19901,200)=DONE, present (5,200).
  - Response: err_code=3, not 2.
  - Stimulus: then rst mid-FAIL.
  - Response: all outputs return to reset values next cycle.
- Stall (macro defined, STALL_MAX=4):
  - Stimulus: 4 consecutive valid holds in RUN.
  - Response: stall=1 after the 4th; a following STEP clears it; err stays 0.
  - Macro undefined: stall stays 0.
